bpsk_demodulator: RTL and testbench

Receive-side counterpart of the BPSK subcarrier modulator. It accepts one frequency-domain sample per subcarrier from the FFT output stream and discards the null subcarriers. Each data subcarrier is hard-sliced to one bit. The block hunts for the 32-bit sync word, then packs the payload bits LSB-first into 40-bit words on an AXI-Stream master, using the same tstrb convention as the transmit side.

---
 rtl/bpsk_demodulator.sv | 195 +++++++++++++++++++
 tb/tb_bpsk_demodulator.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// -----------------------------------------------------------------------------
// bpsk_demodulator
//
// Receive-side BPSK demodulator. Takes one FFT bin per cycle, drops the null
// subcarriers, hard-slices each data subcarrier to one bit (sign of the real
// part), hunts for the 32-bit sync word and then packs the payload bits
// LSB-first into 40-bit words on an AXI-Stream style master port.
//
// Ports:
//   clk          - clock
//   rst          - synchronous, active-low reset
//   reset_demod  - synchronous soft clear, same effect as rst
//   s_valid      - input sample valid
//   s_ready      - input ready (= !m_valid || m_ready)
//   s_data       - FFT bin sample {imag[31:16], real[15:0]}
//   s_last       - last subcarrier of the symbol
//   m_valid      - output word valid
//   m_ready      - downstream ready
//   m_data       - packed bits; sync word is emitted as {8'h00, SYNC_WORD}
//   m_tstrb      - 5'h01 for the sync word, 5'h00 for payload words
//   m_tlast      - set on the last payload word of a packet
//   frame_err    - one-cycle pulse when s_last and the subcarrier count disagree
//   st           - current state (0 = HUNT, 1 = PAYLOAD)
// -----------------------------------------------------------------------------
module bpsk_demodulator #(
    parameter int          FFT_SIZE             = 1024,
    parameter int          DATA_LO_LAST         = 400,
    parameter int          DATA_HI_FIRST        = 623,
    parameter int          C_S_AXIS_TDATA_WIDTH = 32,
    parameter int          C_M_AXIS_TDATA_WIDTH = 40,
    parameter logic [31:0] SYNC_WORD            = 32'hA5A5_0FF0,
    parameter int          PAYLOAD_WORDS        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            reset_demod,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_data,
    input  logic                            s_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_data,
    output logic [4:0]                      m_tstrb,
    output logic                            m_tlast,
    output logic                            frame_err,
    output logic [1:0]                      st
);

    localparam int SUBC_W = $clog2(FFT_SIZE);
    localparam int BIT_W  = $clog2(C_M_AXIS_TDATA_WIDTH);
    localparam int WORD_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

    localparam logic [SUBC_W-1:0] SUBC_MAX  = SUBC_W'(FFT_SIZE - 1);
    localparam logic [SUBC_W-1:0] LO_LAST   = SUBC_W'(DATA_LO_LAST);
    localparam logic [SUBC_W-1:0] HI_FIRST  = SUBC_W'(DATA_HI_FIRST);
    localparam logic [SUBC_W-1:0] HI_LAST   = SUBC_W'(FFT_SIZE - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(C_M_AXIS_TDATA_WIDTH - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(PAYLOAD_WORDS - 1);
    localparam logic [C_M_AXIS_TDATA_WIDTH-1:0] SYNC_OUT = C_M_AXIS_TDATA_WIDTH'(SYNC_WORD);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;

    logic [1:0]                      state_q,     state_d;
    logic [SUBC_W-1:0]               subc_q,      subc_d;
    logic [31:0]                     win_q,       win_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [BIT_W-1:0]                bit_cnt_q,   bit_cnt_d;
    logic [WORD_W-1:0]               word_cnt_q,  word_cnt_d;
    logic                            m_valid_q,   m_valid_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] m_data_q,    m_data_d;
    logic [4:0]                      m_tstrb_q,   m_tstrb_d;
    logic                            m_tlast_q,   m_tlast_d;
    logic                            frame_err_q, frame_err_d;

    logic                            accept;
    logic                            is_data;
    logic                            data_bit;
    logic [31:0]                     win_next;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] shreg_next;
    logic                            unused_s_data;

    // The output register can take a new word whenever it is empty or is
    // being drained this cycle, so the upstream stalls only on true backpressure.
    assign s_ready  = !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready;

    assign is_data  = ((subc_q != '0) && (subc_q <= LO_LAST)) ||
                      ((subc_q >= HI_FIRST) && (subc_q <= HI_LAST));

    // Hard slicer: non-negative real part decodes as 1.
    assign data_bit = ~s_data[15];

    // Both registers shift in at the top so the first bit received ends up
    // in bit 0 once the register is full (LSB-first).
    assign win_next   = {data_bit, win_q[31:1]};
    assign shreg_next = {data_bit, shreg_q[C_M_AXIS_TDATA_WIDTH-1:1]};

    assign unused_s_data = ^{s_data[C_S_AXIS_TDATA_WIDTH-1:16], s_data[14:0]};

    always_comb begin
        state_d     = state_q;
        subc_d      = subc_q;
        win_d       = win_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        m_valid_d   = m_valid_q && !m_ready;
        m_data_d    = m_data_q;
        m_tstrb_d   = m_tstrb_q;
        m_tlast_d   = m_tlast_q;
        frame_err_d = 1'b0;

        if (accept) begin
            // s_last realigns the counter to the start of the next symbol even
            // when it arrives early; packing is not disturbed by misalignment.
            if (s_last || (subc_q == SUBC_MAX)) begin
                subc_d = '0;
            end else begin
                subc_d = subc_q + 1'b1;
            end
            frame_err_d = s_last ^ (subc_q == SUBC_MAX);

            if (is_data) begin
                if (state_q == ST_HUNT) begin
                    win_d = win_next;
                    if (win_next == SYNC_WORD) begin
                        m_valid_d  = 1'b1;
                        m_data_d   = SYNC_OUT;
                        m_tstrb_d  = 5'h01;
                        m_tlast_d  = 1'b0;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        state_d    = ST_PAYLOAD;
                    end
                end else begin
                    shreg_d = shreg_next;
                    if (bit_cnt_q == BIT_LAST) begin
                        m_valid_d = 1'b1;
                        m_data_d  = shreg_next;
                        m_tstrb_d = 5'h00;
                        m_tlast_d = (word_cnt_q == WORD_LAST);
                        bit_cnt_d = '0;
                        if (word_cnt_q == WORD_LAST) begin
                            word_cnt_d = '0;
                            win_d      = '0;
                            state_d    = ST_HUNT;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || reset_demod) begin
            state_q     <= ST_HUNT;
            subc_q      <= '0;
            win_q       <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_tstrb_q   <= '0;
            m_tlast_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            subc_q      <= subc_d;
            win_q       <= win_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_tstrb_q   <= m_tstrb_d;
            m_tlast_q   <= m_tlast_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_tstrb   = m_tstrb_q;
    assign m_tlast   = m_tlast_q;
    assign frame_err = frame_err_q;
    assign st        = state_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// -----------------------------------------------------------------------------
// tb_bpsk_demodulator
//
// Self-checking bench for bpsk_demodulator. Expected output words are pushed
// to a queue as stimulus is generated and popped by a monitor whenever the
// DUT hands a word over (m_valid && m_ready).
// -----------------------------------------------------------------------------
module tb_bpsk_demodulator;

    localparam logic [31:0] SYNC      = 32'hA5A5_0FF0;
    localparam logic [39:0] SYNC_OUT  = {8'h00, 32'hA5A5_0FF0};
    localparam logic [39:0] ALT_WORD  = 40'h55_5555_5555;
    localparam int          FFT       = 1024;
    localparam int          NWORDS    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        reset_demod;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [39:0] m_data;
    logic [4:0]  m_tstrb;
    logic        m_tlast;
    logic        frame_err;
    logic [1:0]  st;

    typedef struct packed {
        logic [39:0] data;
        logic [4:0]  tstrb;
        logic        tlast;
    } out_word_t;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        exp_bit;
    } slice_vec_t;

    out_word_t  exp_q[$];
    out_word_t  mon_exp;
    slice_vec_t vecs[8];

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;
    int bench_subc = 0;

    always #5 clk = ~clk;

    bpsk_demodulator dut (
        .clk         (clk),
        .rst         (rst),
        .reset_demod (reset_demod),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_tstrb     (m_tstrb),
        .m_tlast     (m_tlast),
        .frame_err   (frame_err),
        .st          (st)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor and frame_err pulse counter, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst && !reset_demod) begin
            if (frame_err) err_pulses++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got data 0x%0h tstrb 0x%0h, expected no word", m_data, m_tstrb);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("out_word{data,tstrb,tlast}", {18'b0, m_data, m_tstrb, m_tlast}, {18'b0, mon_exp});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit isData(input int s);
        return ((s >= 1) && (s <= 400)) || ((s >= 623) && (s <= FFT - 2));
    endfunction

    task automatic pushWord(input logic [39:0] data, input logic [4:0] tstrb, input logic tlast);
        out_word_t w;
        w.data  = data;
        w.tstrb = tstrb;
        w.tlast = tlast;
        exp_q.push_back(w);
    endtask

    // Drives one sample and waits (bounded) until it is accepted; returns
    // 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [15:0] re, input logic [15:0] im, input logic last);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = {im, re};
        s_last  = last;
        while (!s_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: s_ready=0 after %0d cycles, expected 1", waited);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        bench_subc = (last || bench_subc == FFT - 1) ? 0 : bench_subc + 1;
    endtask

    task automatic sendNull();
        applyStimulus(16'h8000, 16'h0000, bench_subc == FFT - 1);
    endtask

    task automatic sendData(input logic [15:0] re, input logic [15:0] im);
        while (!isData(bench_subc)) sendNull();
        applyStimulus(re, im, 1'b0);
    endtask

    task automatic sendBit(input logic b);
        sendData(b ? 16'h7FFF : 16'h8000, 16'($urandom));
    endtask

    task automatic sendSync();
        for (int i = 0; i < 32; i++) sendBit(SYNC[i]);
    endtask

    task automatic finishSymbol();
        while (bench_subc != 0) sendNull();
    endtask

    task automatic pushAltPacket();
        for (int w = 0; w < NWORDS; w++) pushWord(ALT_WORD, 5'h00, w == NWORDS - 1);
    endtask

    initial begin
        logic [39:0] tword;

        rst = 1'b0; reset_demod = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;

        vecs[0] = '{re: 16'h7FFF, im: 16'h0000, exp_bit: 1'b1};
        vecs[1] = '{re: 16'h0000, im: 16'hFFFF, exp_bit: 1'b1};
        vecs[2] = '{re: 16'h8000, im: 16'h7FFF, exp_bit: 1'b0};
        vecs[3] = '{re: 16'hFFFF, im: 16'h0000, exp_bit: 1'b0};
        vecs[4] = '{re: 16'h0001, im: 16'h8000, exp_bit: 1'b1};
        vecs[5] = '{re: 16'hC000, im: 16'h1234, exp_bit: 1'b0};
        vecs[6] = '{re: 16'h8001, im: 16'hFFFF, exp_bit: 1'b0};
        vecs[7] = '{re: 16'h4000, im: 16'h8000, exp_bit: 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_m_tstrb", m_tstrb, 0);
        checkOutput("reset_m_tlast", m_tlast, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_st", st, 0);
        checkOutput("reset_s_ready", s_ready, 1);
        rst = 1'b1;
        $display("[TB] reset released");

        // Sync detect on bins 1..32 with one-cycle latency
        pushWord(SYNC_OUT, 5'h01, 1'b0);
        for (int i = 0; i < 31; i++) sendBit(SYNC[i]);
        checkOutput("no_early_sync", m_valid, 0);
        sendBit(SYNC[31]);
        checkOutput("sync_latency_valid", m_valid, 1);
        checkOutput("sync_tstrb", m_tstrb, 5'h01);
        checkOutput("sync_data", m_data, SYNC_OUT);
        checkOutput("sync_st", st, 1);

        // Alternating payload across the band gap
        pushAltPacket();
        for (int i = 0; i < 639; i++) sendBit((i % 2) == 0);
        checkOutput("payload_st_before_last", st, 1);
        sendBit(1'b0);
        checkOutput("payload_last_valid", m_valid, 1);
        checkOutput("payload_last_tlast", m_tlast, 1);
        checkOutput("payload_st_after", st, 0);
        finishSymbol();
        $display("[TB] first packet done");

        // Backpressure: sync word held with m_ready low for 10 cycles
        m_ready = 1'b0;
        pushWord(SYNC_OUT, 5'h01, 1'b0);
        sendSync();
        pushAltPacket();
        s_valid = 1'b1;
        s_data  = {16'h0000, 16'h7FFF};
        s_last  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checkOutput("stall_s_ready", s_ready, 0);
            checkOutput("stall_m_data", m_data, SYNC_OUT);
        end
        checkOutput("stall_m_valid", m_valid, 1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        bench_subc++;
        for (int i = 1; i < 640; i++) sendBit((i % 2) == 0);
        checkOutput("stall_packet_st", st, 0);
        finishSymbol();
        $display("[TB] backpressure packet done");

        // Table-driven slicer vectors
        pushWord(SYNC_OUT, 5'h01, 1'b0);
        sendSync();
        for (int w = 0; w < NWORDS; w++) begin
            for (int k = 0; k < 40; k++) tword[k] = vecs[k % 8].exp_bit;
            pushWord(tword, 5'h00, w == NWORDS - 1);
            for (int k = 0; k < 40; k++) sendData(vecs[k % 8].re, vecs[k % 8].im);
        end
        checkOutput("table_packet_st", st, 0);
        finishSymbol();
        checkOutput("aligned_no_frame_err", err_pulses, 0);

        // Misaligned s_last at subcarrier 500
        while (bench_subc != 500) sendNull();
        applyStimulus(16'h8000, 16'h0000, 1'b1);
        checkOutput("misalign_pulse", frame_err, 1);
        sendNull();
        checkOutput("misalign_pulse_width", frame_err, 0);
        finishSymbol();
        checkOutput("misalign_realigned", err_pulses, 1);

        // 1024 samples without s_last
        for (int i = 0; i < FFT; i++) applyStimulus(16'h8000, 16'h0000, 1'b0);
        checkOutput("missing_last_pulse", frame_err, 1);
        sendNull();
        finishSymbol();
        checkOutput("missing_last_wrap", err_pulses, 2);

        // Soft clear after 7 words plus 13 bits
        pushWord(SYNC_OUT, 5'h01, 1'b0);
        sendSync();
        for (int w = 0; w < 7; w++) pushWord(ALT_WORD, 5'h00, 1'b0);
        for (int i = 0; i < 7 * 40 + 13; i++) sendBit((i % 2) == 0);
        checkOutput("pre_clear_st", st, 1);
        reset_demod = 1'b1;
        @(posedge clk); #1;
        reset_demod = 1'b0;
        bench_subc = 0;
        checkOutput("clear_m_valid", m_valid, 0);
        checkOutput("clear_st", st, 0);
        for (int i = 0; i < 200; i++) sendBit((i % 2) == 0);
        checkOutput("no_output_without_sync", m_valid, 0);
        checkOutput("hunt_after_clear", st, 0);
        pushWord(SYNC_OUT, 5'h01, 1'b0);
        sendSync();
        checkOutput("resync_st", st, 1);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
